// File: rtl/rf_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared types for the register-file writeback arbiter and its scoreboard.
//   reg_idx_t : architectural register index (5 bits, 32 registers)
//   word_t    : default-width register value
//   wb_src_e  : which source owns the register-file write port this cycle
// -----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0]  word_t;

    typedef enum logic [1:0] {
        WB_NONE       = 2'd0,
        WB_PIPE       = 2'd1,
        WB_MDU_DIRECT = 2'd2,
        WB_MDU_HOLD   = 2'd3
    } wb_src_e;

    // x0 is hard-wired; writes to it and hazards on it are meaningless
    function automatic logic idx_nonzero(input reg_idx_t idx);
        return (idx != {REG_IDX_W{1'b0}});
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_scoreboard
// Tracks which architectural registers have an MDU operation in flight and
// reports decode-stage hazards against them.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   set_en, set_idx        : MDU op issued; mark destination pending
//   clr_en, clr_idx        : MDU result written this cycle; retire destination
//   rs1, rs2, rd           : decode-stage register indices
//   hazard_stall           : decode must stall (combinational)
// -----------------------------------------------------------------------------
module rf_wb_arbiter_scoreboard
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    output logic                 hazard_stall
);

    logic [NREGS-1:0] pending_r;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;
    logic [NREGS-1:0] pending_next_s;
    logic             hit_rs1_s;
    logic             hit_rs2_s;
    logic             hit_rd_s;

    // A register being written by the MDU this cycle is already visible via
    // the regfile's write-to-read bypass, so it no longer counts as a hazard.
    function automatic logic reg_hit(
        input reg_idx_t         idx,
        input logic [NREGS-1:0] pend,
        input logic             cen,
        input reg_idx_t         cidx
    );
        return idx_nonzero(idx) && pend[idx] && !(cen && (cidx == idx));
    endfunction

    // Build set/clear masks; set is applied after clear so a same-cycle
    // re-issue of the retiring register stays pending.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        if (set_en && idx_nonzero(set_idx)) begin
            set_mask_s[set_idx] = 1'b1;
        end else begin
            set_mask_s = '0;
        end
        if (clr_en && idx_nonzero(clr_idx)) begin
            clr_mask_s[clr_idx] = 1'b1;
        end else begin
            clr_mask_s = '0;
        end
        pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
    end

    // Pending-vector state register
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= '0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Decode hazard compare against the pending vector
    always_comb begin
        hit_rs1_s = reg_hit(rs1, pending_r, clr_en, clr_idx);
        hit_rs2_s = reg_hit(rs2, pending_r, clr_en, clr_idx);
        hit_rd_s  = reg_hit(rd,  pending_r, clr_en, clr_idx);
        if (rst) begin
            hazard_stall = 1'b0;
        end else begin
            hazard_stall = hit_rs1_s | hit_rs2_s | hit_rd_s;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Owns the single register-file write port and shares it between the in-order
// pipeline writeback (always highest priority) and the out-of-order MDU
// result. A one-entry hold register absorbs an MDU result that collides with a
// pipeline write; a starvation counter raises stall_req when that held result
// keeps losing. A scoreboard flags decode hazards on MDU destinations.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   pipe_wb_load/pipe_wb_rd/pipe_wb_data  : pipeline writeback
//   mdu_valid/mdu_ready/mdu_rd/mdu_data   : MDU result handshake
//   issue_mdu/issue_rd                    : MDU op issued by decode
//   dec_rs1/dec_rs2/dec_rd, hazard_stall  : decode hazard query
//   stall_req                             : registered writeback hold-off request
//   rf_load/rf_dest/rf_in                 : register-file write port
// -----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_wb_load,
    input  logic [REG_IDX_W-1:0] pipe_wb_rd,
    input  logic [XLEN-1:0]      pipe_wb_data,
    input  logic                 mdu_valid,
    output logic                 mdu_ready,
    input  logic [REG_IDX_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]      mdu_data,
    input  logic                 issue_mdu,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic [REG_IDX_W-1:0] dec_rd,
    output logic                 hazard_stall,
    output logic                 stall_req,
    output logic                 rf_load,
    output logic [REG_IDX_W-1:0] rf_dest,
    output logic [XLEN-1:0]      rf_in
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic                 pipe_win_s;
    logic                 mdu_keep_s;
    logic                 capture_s;
    logic                 drain_s;
    wb_src_e              src_s;
    logic                 clr_en_s;
    logic [REG_IDX_W-1:0] clr_idx_s;
    logic [CNT_W-1:0]     starve_next_s;

    logic                 hold_valid_r;
    logic [REG_IDX_W-1:0] hold_rd_r;
    logic [XLEN-1:0]      hold_data_r;
    logic [CNT_W-1:0]     starve_cnt_r;
    logic                 stall_req_r;

    // Ready depends only on the hold flop, never on mdu_valid
    assign mdu_ready = !hold_valid_r && !rst;
    assign stall_req = stall_req_r;

    // Qualify the two sources; an rd=0 MDU result is accepted then dropped
    always_comb begin
        pipe_win_s = pipe_wb_load && idx_nonzero(pipe_wb_rd);
        mdu_keep_s = mdu_valid && mdu_ready && idx_nonzero(mdu_rd);
        capture_s  = mdu_keep_s && pipe_win_s;
    end

    // Write-port source select: pipeline > held MDU result > direct MDU result
    always_comb begin
        src_s = WB_NONE;
        if (rst) begin
            src_s = WB_NONE;
        end else if (pipe_win_s) begin
            src_s = WB_PIPE;
        end else if (hold_valid_r) begin
            src_s = WB_MDU_HOLD;
        end else if (mdu_keep_s) begin
            src_s = WB_MDU_DIRECT;
        end else begin
            src_s = WB_NONE;
        end
    end

    // Register-file write-port mux
    always_comb begin
        rf_load = 1'b0;
        rf_dest = '0;
        rf_in   = '0;
        case (src_s)
            WB_PIPE: begin
                rf_load = 1'b1;
                rf_dest = pipe_wb_rd;
                rf_in   = pipe_wb_data;
            end
            WB_MDU_HOLD: begin
                rf_load = 1'b1;
                rf_dest = hold_rd_r;
                rf_in   = hold_data_r;
            end
            WB_MDU_DIRECT: begin
                rf_load = 1'b1;
                rf_dest = mdu_rd;
                rf_in   = mdu_data;
            end
            default: begin
                rf_load = 1'b0;
                rf_dest = '0;
                rf_in   = '0;
            end
        endcase
    end

    // Scoreboard clear port and starvation-counter next value
    always_comb begin
        drain_s   = (src_s == WB_MDU_HOLD);
        clr_en_s  = (src_s == WB_MDU_HOLD) || (src_s == WB_MDU_DIRECT);
        clr_idx_s = drain_s ? hold_rd_r : mdu_rd;
        if (drain_s) begin
            starve_next_s = '0;
        end else if (hold_valid_r && pipe_win_s && (starve_cnt_r != LIMIT_C)) begin
            starve_next_s = starve_cnt_r + ONE_C;
        end else begin
            starve_next_s = starve_cnt_r;
        end
    end

    // Hold register, starvation counter and stall request state
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_rd_r    <= '0;
            hold_data_r  <= '0;
            starve_cnt_r <= '0;
            stall_req_r  <= 1'b0;
        end else begin
            if (drain_s) begin
                hold_valid_r <= 1'b0;
            end else if (capture_s) begin
                hold_valid_r <= 1'b1;
            end else begin
                hold_valid_r <= hold_valid_r;
            end
            if (capture_s) begin
                hold_rd_r   <= mdu_rd;
                hold_data_r <= mdu_data;
            end else begin
                hold_rd_r   <= hold_rd_r;
                hold_data_r <= hold_data_r;
            end
            starve_cnt_r <= starve_next_s;
            // Draining zeroes the counter, which also drops the request
            stall_req_r  <= (starve_next_s == LIMIT_C);
        end
    end

    rf_wb_arbiter_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (issue_mdu),
        .set_idx      (issue_rd),
        .clr_en       (clr_en_s),
        .clr_idx      (clr_idx_s),
        .rs1          (dec_rs1),
        .rs2          (dec_rs2),
        .rd           (dec_rd),
        .hazard_stall (hazard_stall)
    );

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Owns the single register-file write port and shares it between two sources: the in-order pipeline writeback and the out-of-order multiply/divide unit (MDU) result. It also keeps a per-register scoreboard of destinations with MDU operations in flight, and reports decode-stage RAW/WAW hazards against it. It sits between the MEM/WB stage, the MDU result interface, the decode hazard logic and the register file write inputs (load/dest/in).

Parameters:
XLEN, 32, data width of register values
NREGS, 32, architectural register count; index width is clog2(NREGS)
STARVE_LIMIT, 4, consecutive cycles a buffered MDU result may lose arbitration before stall_req asserts (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pipe_wb_load  in  1  pipeline writeback valid this cycle
pipe_wb_rd  in  5  pipeline writeback destination
pipe_wb_data  in  XLEN  pipeline writeback value
mdu_valid  in  1  MDU result valid
mdu_ready  out  1  arbiter accepts MDU result this cycle
mdu_rd  in  5  MDU result destination
mdu_data  in  XLEN  MDU result value
issue_mdu  in  1  decode issues an MDU op this cycle (already hazard-free)
issue_rd  in  5  destination of issued MDU op
dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage source/dest indices
hazard_stall  out  1  decode must stall: scoreboard conflict
stall_req  out  1  registered request for pipeline to hold off writeback
rf_load  out  1  to regfile load
rf_dest  out  5  to regfile dest
rf_in  out  XLEN  to regfile in

Behaviour:
- State: pending[NREGS-1:0], hold_valid, hold_rd, hold_data, starve_cnt, stall_req. Reset clears all to 0. While rst=1, rf_load=0, hazard_stall=0, mdu_ready=0.
- pipe_win = pipe_wb_load && pipe_wb_rd != 0. The pipeline always has priority.
- mdu_ready = !hold_valid && !rst (derived from a flop, with no combinational path from mdu_valid).
- Write-port select, combinational, same cycle:
  - If pipe_win: write the pipeline value.
  - Else if hold_valid: write hold_rd/hold_data; hold_valid <= 0.
  - Else if mdu_valid && mdu_ready: write mdu_rd/mdu_data directly, with zero latency.
  - Else: rf_load = 0.
- If mdu_valid && mdu_ready && pipe_win: capture the MDU result into the hold register; hold_valid <= 1.
- Throughput is one MDU result per cycle when uncontended, and one per 2 cycles after a capture.
- pipe_wb_load with rd=0 is dropped (rf_load=0); it does not consume the port.
- An MDU result with rd=0 is accepted and discarded; it never sets pending.
- Scoreboard:
  - issue_mdu with issue_rd != 0 sets pending[issue_rd] at the next edge.
  - An MDU write (direct or hold) clears pending[its rd] at the same edge.
  - Same-cycle set and clear of the same index: set wins (a new op is in flight).
- clear_now = the index being written by the MDU this cycle, combinational.
  - hazard_stall = any of dec_rs1/dec_rs2/dec_rd (nonzero) hits pending & ~clear_now.
  - The regfile's internal write-to-read bypass covers the write cycle, so decode proceeds in the clear cycle.
- Starvation:
  - starve_cnt increments each cycle hold_valid && pipe_win, saturating at STARVE_LIMIT. It clears when the hold drains.
  - stall_req <= 1 when the next starve_cnt == STARVE_LIMIT.
  - stall_req <= 0 at the edge the hold drains.
  - Contract: while stall_req=1, the pipeline holds pipe_wb_load=0. A violation still gives the pipeline priority; the bench flags it as an assertion error.
- Pipeline flush does not touch the scoreboard or the hold register: in-flight MDU ops always retire.
- rst mid-operation: pending, hold and stall_req are cleared in one cycle, and any held result is lost. The MDU is reset by the same rst.

Decomposition:
- Shared package rv_pkg: reg_idx_t (5-bit), word_t (XLEN), and enum wb_src_e {WB_NONE, WB_PIPE, WB_MDU_DIRECT, WB_MDU_HOLD} for the select mux and debug.
- One sub-module, rf_scoreboard: pending vector, set/clear and hazard compare.
- Arbitration, hold register and starvation counter stay in rf_wb_arbiter.

Test Plan:
- Uncontended MDU: issue rd=5; later mdu_valid rd=5 data=0x1234 with pipe idle -> same-cycle rf_load=1, dest=5, in=0x1234; pending[5] cleared at the edge.
- Collision: pipe writes rd=3 data=0xA while MDU offers rd=7 data=0xB -> cycle 0: rf writes x3=0xA, hold captures. Cycle 1: rf writes x7=0xB, mdu_ready=0. Cycle 2: mdu_ready=1.
- Hazard: pending[9] set; decode dec_rs2=9 -> hazard_stall=1 until the MDU write of x9, and hazard_stall=0 in that same cycle. dec_rs1=0 never stalls.
- Starvation, STARVE_LIMIT=4: hold valid with pipe_win for 4 cycles -> stall_req rises after the 4th loss. Pipe drops load -> hold drains -> stall_req=0 the next cycle.
- Set/clear race: the MDU retires x12 while issue_mdu rd=12 in the same cycle -> pending[12] ends at 1.
- Reset mid-op: hold_valid=1, pending=0x80 when rst pulses -> next cycle all state 0, rf_load=0, mdu_ready=1 after rst drops.
